multi_cycle_ctrl: RTL and testbench
===================================

MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 SHALL have parameter OPC_HALT, default 6'b111111, meaning the opcode that enters HALT.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset; asynchronous, active-low.
REQ-004 SHALL have port op, input, 6, the opcode field of the instruction register.
REQ-005 SHALL have port funct, input, 6, the R-type function field.
REQ-006 SHALL have port zero, input, 1, the ALU zero flag.
REQ-007 SHALL have port pc_write, output, 1, the PC load enable.
REQ-008 SHALL have port pc_src, output, 2, the PC source: 00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 SHALL have ports ir_write, mem_write, reg_write, reg_dst, mem_to_reg and ext_sel, each output, 1; ext_sel is 1 for sign extend and 0 for zero extend.
REQ-010 SHALL have port alu_src_a, output, 1: 0 selects PC, 1 selects reg A.
REQ-011 SHALL have port alu_src_b, output, 2: 00 selects reg B, 01 selects constant 4, 10 selects extended immediate, 11 selects extended immediate shifted left by 2.
REQ-012 SHALL have port alu_op, output, 3: ADD 000, SUB 001, AND 010, OR 011, SLT 100.
REQ-013 SHALL have port state, output, 3, the current state (debug); and port halted, output, 1, asserted while in HALT.

Function
REQ-014 SHALL be a Moore FSM with states IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to IF.
REQ-015 Outputs SHALL decode combinationally from state, op and funct; every output not named in a state SHALL be 0 in that state.
REQ-016 IF SHALL assert ir_write=1 and pc_write=1, with alu_src_a=0, alu_src_b=01, alu_op=ADD and pc_src=00, then go to ID.
REQ-017 ID SHALL drive alu_src_a=0, alu_src_b=11, ext_sel=1 and alu_op=ADD (branch target into ALUOut).
REQ-018 ID transitions SHALL be:
- j (000010): pc_write=1, pc_src=10, go to IF.
- OPC_HALT: go to HALT.
- R (000000), addi (001000), ori (001101), lw (100011), sw (101011), beq (000100): go to EXE.
- Any other opcode: go to IF (NOP).
REQ-019 EXE for R-type SHALL drive alu_src_a=1, alu_src_b=00, and alu_op from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, anything else ADD; then go to WB.
REQ-020 EXE for addi, lw and sw SHALL drive alu_src_a=1, alu_src_b=10, ext_sel=1, alu_op=ADD; addi goes to WB, lw and sw go to MEM.
REQ-021 EXE for ori SHALL drive alu_src_a=1, alu_src_b=10, ext_sel=0, alu_op=OR, then go to WB.
REQ-022 EXE for beq SHALL drive alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_src=01 and pc_write=zero, then go to IF.
REQ-023 MEM for sw SHALL assert mem_write=1 and go to IF; MEM for lw SHALL go to WB.
REQ-024 WB SHALL assert reg_write=1 except for R-type with an unlisted funct. reg_dst=1 only for R-type; mem_to_reg=1 only for lw. WB then goes to IF.
REQ-025 Cycle counts SHALL be: j 2, beq 3, R/addi/ori/sw 4, lw 5.
REQ-026 HALT SHALL hold all enables at 0 and halted=1 until reset.
REQ-027 op and funct SHALL be sampled only in the cycle that uses them; the IR is stable from ID onward.

Reset
REQ-028 While rst_n=0, state SHALL be IF and every output, including ir_write and pc_write, SHALL be 0 (enables gated by rst_n).
REQ-029 Reset asserted mid-instruction SHALL abort immediately with no write enable asserted; the first rising edge after release SHALL execute IF.

Structure
REQ-030 State codes, opcode, funct, alu_op and alu_src_b encodings SHALL live in the shared package cpu_ctrl_pkg, which the datapath muxes also use.
REQ-031 ALU-op decoding SHALL be the sub-module alu_op_dec (inputs state, op, funct; output alu_op). There SHALL be no other sub-module.

Verification
REQ-032 Scenario: reset release, op=000000, funct=100010 -> states IF,ID,EXE,WB,IF; EXE shows alu_op=001 and alu_src_b=00; WB shows reg_write=1 and reg_dst=1.
REQ-033 Scenario: lw (100011) -> 5 cycles; EXE shows alu_src_b=10 and ext_sel=1; WB shows mem_to_reg=1; mem_write=0 throughout.
REQ-034 Scenario: beq with zero=1, then beq with zero=0 -> EXE pc_write=1 and pc_src=01 for the first, pc_write=0 for the second; ID alu_src_b=11 in both.
REQ-035 Scenario: ori (001101) -> EXE ext_sel=0 and alu_op=011; sw (101011) -> MEM mem_write=1, reg_write never asserted.
REQ-036 Scenario: op=OPC_HALT -> HALT after ID, halted=1 for 20 cycles; then rst_n low mid-cycle -> state=0 and all outputs 0 without waiting for a clock edge.
REQ-037 Scenario: op=111110 (undefined), then j (000010) -> NOP takes IF,ID,IF with no writes; j asserts pc_write=1 and pc_src=10 in ID.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller and the datapath muxes it steers.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    function automatic logic funct_known(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

    // Unknown R-type functions fall back to ADD.
    function automatic logic [2:0] funct_alu_op(input logic [5:0] funct);
        case (funct)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_dec.sv
// ALU operation select; only EXE carries anything other than ADD.
module alu_op_dec
    import cpu_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        if (state == S_EXE) begin
            case (op)
                OP_R:    alu_op = funct_alu_op(funct);
                OP_ORI:  alu_op = ALU_OR;
                OP_BEQ:  alu_op = ALU_SUB;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Moore control FSM for a multi-cycle MIPS-like datapath; outputs decode from
// the current state plus the stable IR fields and are forced low during reset.
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter logic [5:0] OPC_HALT = 6'b111111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       ext_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic [2:0] state,
    output logic       halted
);

    state_t     state_q, state_d;
    logic       pc_write_c, ir_write_c, mem_write_c, reg_write_c;
    logic       reg_dst_c, mem_to_reg_c, ext_sel_c, alu_src_a_c, halted_c;
    logic [1:0] pc_src_c, alu_src_b_c;
    logic [2:0] alu_op_c;

    alu_op_dec u_alu_op_dec (
        .state  (state_q),
        .op     (op),
        .funct  (funct),
        .alu_op (alu_op_c)
    );

    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        pc_src_c     = PC_SRC_ALU;
        ir_write_c   = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        reg_dst_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        ext_sel_c    = 1'b0;
        alu_src_a_c  = 1'b0;
        alu_src_b_c  = SRC_B_REG;
        halted_c     = 1'b0;
        case (state_q)
            S_IF: begin
                ir_write_c  = 1'b1;
                pc_write_c  = 1'b1;
                alu_src_b_c = SRC_B_FOUR;
                state_d     = S_ID;
            end
            S_ID: begin
                // Branch target is precomputed here into ALUOut.
                alu_src_b_c = SRC_B_IMM_SH;
                ext_sel_c   = 1'b1;
                if (op == OP_J) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = PC_SRC_JUMP;
                    state_d    = S_IF;
                end else if (op == OPC_HALT) begin
                    state_d = S_HALT;
                end else if (op == OP_R || op == OP_ADDI || op == OP_ORI ||
                             op == OP_LW || op == OP_SW || op == OP_BEQ) begin
                    state_d = S_EXE;
                end else begin
                    state_d = S_IF;
                end
            end
            S_EXE: begin
                alu_src_a_c = 1'b1;
                state_d     = S_IF;
                case (op)
                    OP_R: begin
                        alu_src_b_c = SRC_B_REG;
                        state_d     = S_WB;
                    end
                    OP_ADDI, OP_LW, OP_SW: begin
                        alu_src_b_c = SRC_B_IMM;
                        ext_sel_c   = 1'b1;
                        state_d     = (op == OP_ADDI) ? S_WB : S_MEM;
                    end
                    OP_ORI: begin
                        alu_src_b_c = SRC_B_IMM;
                        state_d     = S_WB;
                    end
                    OP_BEQ: begin
                        alu_src_b_c = SRC_B_REG;
                        pc_src_c    = PC_SRC_ALUOUT;
                        pc_write_c  = zero;
                    end
                    default: alu_src_a_c = 1'b0;
                endcase
            end
            S_MEM: begin
                if (op == OP_LW) begin
                    state_d = S_WB;
                end else begin
                    mem_write_c = (op == OP_SW);
                    state_d     = S_IF;
                end
            end
            S_WB: begin
                reg_write_c  = !(op == OP_R && !funct_known(funct));
                reg_dst_c    = (op == OP_R);
                mem_to_reg_c = (op == OP_LW);
                state_d      = S_IF;
            end
            S_HALT: begin
                halted_c = 1'b1;
                state_d  = S_HALT;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IF;
        end else begin
            state_q <= state_d;
        end
    end

    // Gating by rst_n makes an abort take effect without waiting for a clock edge.
    assign state      = state_q;
    assign pc_write   = rst_n & pc_write_c;
    assign pc_src     = rst_n ? pc_src_c : 2'b00;
    assign ir_write   = rst_n & ir_write_c;
    assign mem_write  = rst_n & mem_write_c;
    assign reg_write  = rst_n & reg_write_c;
    assign reg_dst    = rst_n & reg_dst_c;
    assign mem_to_reg = rst_n & mem_to_reg_c;
    assign ext_sel    = rst_n & ext_sel_c;
    assign alu_src_a  = rst_n & alu_src_a_c;
    assign alu_src_b  = rst_n ? alu_src_b_c : 2'b00;
    assign alu_op     = rst_n ? alu_op_c : 3'b000;
    assign halted     = rst_n & halted_c;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed cycle-by-cycle check of the multi-cycle controller: a table of
// per-cycle inputs and expected outputs, plus hand-written reset/halt sequences.
module tb_multi_cycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       pc_write, ir_write, mem_write, reg_write, reg_dst;
    logic       mem_to_reg, ext_sel, alu_src_a, halted;
    logic [1:0] pc_src, alu_src_b;
    logic [2:0] alu_op, state;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw;
        logic       mw;
        logic       rw;
        logic       rd;
        logic       m2r;
        logic       ext;
        logic       sa;
        logic [1:0] sb;
        logic [2:0] aop;
        logic       h;
    } out_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];
    out_t act;
    int   checks = 0;
    int   failures = 0;

    multi_cycle_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .ir_write   (ir_write),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .ext_sel    (ext_sel),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .state      (state),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    assign act = {state, pc_write, pc_src, ir_write, mem_write, reg_write, reg_dst,
                  mem_to_reg, ext_sel, alu_src_a, alu_src_b, alu_op, halted};

    function automatic out_t mk(input logic [2:0] st, input logic pcw, input logic [1:0] pcs,
                                input logic irw, input logic mw, input logic rw,
                                input logic rd, input logic m2r, input logic ext,
                                input logic sa, input logic [1:0] sb,
                                input logic [2:0] aop, input logic h);
        out_t o;
        o = {st, pcw, pcs, irw, mw, rw, rd, m2r, ext, sa, sb, aop, h};
        return o;
    endfunction

    function automatic out_t o_zero();
        return mk(3'd0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    endfunction
    function automatic out_t o_if();
        return mk(3'd0, 1, 2'b00, 1, 0, 0, 0, 0, 0, 0, 2'b01, 3'b000, 0);
    endfunction
    function automatic out_t o_id();
        return mk(3'd1, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 2'b11, 3'b000, 0);
    endfunction
    function automatic out_t o_idj();
        return mk(3'd1, 1, 2'b10, 0, 0, 0, 0, 0, 1, 0, 2'b11, 3'b000, 0);
    endfunction
    function automatic out_t o_exe(input logic [1:0] sb, input logic ext,
                                   input logic [2:0] aop, input logic pcw,
                                   input logic [1:0] pcs);
        return mk(3'd2, pcw, pcs, 0, 0, 0, 0, 0, ext, 1, sb, aop, 0);
    endfunction
    function automatic out_t o_mem(input logic mw);
        return mk(3'd3, 0, 2'b00, 0, mw, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0);
    endfunction
    function automatic out_t o_wb(input logic rw, input logic rd, input logic m2r);
        return mk(3'd4, 0, 2'b00, 0, 0, rw, rd, m2r, 0, 0, 2'b00, 3'b000, 0);
    endfunction
    function automatic out_t o_halt();
        return mk(3'd5, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 1);
    endfunction

    task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z, input out_t e);
        vecs.push_back({o, f, z, e});
    endtask

    task automatic check(input string nm, input int idx, input out_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%05h exp=%05h (state got %0d exp %0d)",
                     nm, idx, act, exp, act.st, exp.st);
        end
    endtask

    // R-type: IF, ID, EXE, WB.
    task automatic add_r(input logic [5:0] f, input logic [2:0] aop, input logic rw);
        add(6'b000000, f, 1'b1, o_if());
        add(6'b000000, f, 1'b1, o_id());
        add(6'b000000, f, 1'b1, o_exe(2'b00, 1'b0, aop, 1'b0, 2'b00));
        add(6'b000000, f, 1'b1, o_wb(rw, 1'b1, 1'b0));
    endtask

    initial begin
        add_r(6'b100010, 3'b001, 1'b1);
        add_r(6'b101010, 3'b100, 1'b1);
        add_r(6'b100100, 3'b010, 1'b1);
        add_r(6'b100101, 3'b011, 1'b1);
        add_r(6'b100000, 3'b000, 1'b1);
        add_r(6'b000111, 3'b000, 1'b0);
        // lw: five cycles, funct carries junk that must be ignored.
        add(6'b100011, 6'b100010, 1'b1, o_if());
        add(6'b100011, 6'b100010, 1'b1, o_id());
        add(6'b100011, 6'b100010, 1'b1, o_exe(2'b10, 1'b1, 3'b000, 1'b0, 2'b00));
        add(6'b100011, 6'b100010, 1'b1, o_mem(1'b0));
        add(6'b100011, 6'b100010, 1'b1, o_wb(1'b1, 1'b0, 1'b1));
        add(6'b101011, 6'b000000, 1'b0, o_if());
        add(6'b101011, 6'b000000, 1'b0, o_id());
        add(6'b101011, 6'b000000, 1'b0, o_exe(2'b10, 1'b1, 3'b000, 1'b0, 2'b00));
        add(6'b101011, 6'b000000, 1'b0, o_mem(1'b1));
        add(6'b000100, 6'b000000, 1'b1, o_if());
        add(6'b000100, 6'b000000, 1'b1, o_id());
        add(6'b000100, 6'b000000, 1'b1, o_exe(2'b00, 1'b0, 3'b001, 1'b1, 2'b01));
        add(6'b000100, 6'b000000, 1'b0, o_if());
        add(6'b000100, 6'b000000, 1'b0, o_id());
        add(6'b000100, 6'b000000, 1'b0, o_exe(2'b00, 1'b0, 3'b001, 1'b0, 2'b01));
        add(6'b001101, 6'b000000, 1'b1, o_if());
        add(6'b001101, 6'b000000, 1'b1, o_id());
        add(6'b001101, 6'b000000, 1'b1, o_exe(2'b10, 1'b0, 3'b011, 1'b0, 2'b00));
        add(6'b001101, 6'b000000, 1'b1, o_wb(1'b1, 1'b0, 1'b0));
        add(6'b001000, 6'b101010, 1'b0, o_if());
        add(6'b001000, 6'b101010, 1'b0, o_id());
        add(6'b001000, 6'b101010, 1'b0, o_exe(2'b10, 1'b1, 3'b000, 1'b0, 2'b00));
        add(6'b001000, 6'b101010, 1'b0, o_wb(1'b1, 1'b0, 1'b0));
        add(6'b111110, 6'b000000, 1'b1, o_if());
        add(6'b111110, 6'b000000, 1'b1, o_id());
        add(6'b000010, 6'b000000, 1'b1, o_if());
        add(6'b000010, 6'b000000, 1'b1, o_idj());

        // Reset held: state IF but every output forced low.
        repeat (2) begin
            @(negedge clk);
            check("reset_hold", 0, o_zero());
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        foreach (vecs[i]) begin
            op    = vecs[i].op;
            funct = vecs[i].funct;
            zero  = vecs[i].zero;
            @(negedge clk);
            check("vec", i, vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Halt: IF, ID, then HALT held regardless of the IR.
        op = 6'b111111;
        @(negedge clk);
        check("halt_if", 0, o_if());
        @(posedge clk);
        #1;
        @(negedge clk);
        check("halt_id", 0, o_id());
        @(posedge clk);
        #1;
        for (int k = 0; k < 20; k++) begin
            op = (k % 2 == 0) ? 6'b000010 : 6'b000000;
            @(negedge clk);
            check("halt_hold", k, o_halt());
            @(posedge clk);
            #1;
        end
        #2 rst_n = 1'b0;
        #1 check("halt_async_rst", 0, o_zero());
        @(posedge clk);
        #1 check("halt_rst_edge", 0, o_zero());
        rst_n = 1'b1;
        #1 check("halt_rst_release", 0, o_if());

        // sw aborted by reset while mem_write is high.
        op = 6'b101011;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_id", 0, o_id());
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_exe", 0, o_exe(2'b10, 1'b1, 3'b000, 1'b0, 2'b00));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_mem", 0, o_mem(1'b1));
        #1 rst_n = 1'b0;
        #1 check("abort_rst", 0, o_zero());
        @(posedge clk);
        #1 rst_n = 1'b1;
        op = 6'b000000;
        funct = 6'b100000;
        @(negedge clk);
        check("abort_if", 0, o_if());
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_next_id", 0, o_id());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
